fetch_queue: RTL and testbench

//  Instruction-fetch stage directly downstream of the PC register. Takes the current PC, issues
//  one-at-a-time requests to instruction memory and buffers returned words in a DEPTH-entry FIFO.

---
 rtl/fetch_queue.sv | 120 ++++++++++++
 tb/tb_fetch_queue.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch stage: issues one fetch at a time to instruction memory
// and buffers returned words for decode; flush discards queued and in-flight words.
module fetch_queue #(
    parameter int          DBITS    = 32,
    parameter int unsigned START_PC = 64,
    parameter int          DEPTH    = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DBITS-1:0] pc,
    input  logic             flush,
    output logic             pcAdvance,
    output logic             imemReq,
    output logic [DBITS-1:0] imemAddr,
    input  logic             imemReqReady,
    input  logic             imemRespValid,
    input  logic [DBITS-1:0] imemRespData,
    output logic             instValid,
    output logic [DBITS-1:0] inst,
    output logic [DBITS-1:0] instPc,
    input  logic             instReady
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_e;

    state_e           state_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic [PW-1:0]    rd_ptr_q;
    logic [PW-1:0]    wr_ptr_q;
    logic [DBITS-1:0] req_pc_q;
    logic [DBITS-1:0] inst_q [DEPTH];
    logic [DBITS-1:0] pc_q   [DEPTH];

    logic accept;
    logic push;
    logic pop;

    assign imemReq   = !reset && (state_q == IDLE) && !flush
                       && (count_q < CW'(DEPTH));
    assign accept    = imemReq && imemReqReady;
    assign pcAdvance = accept;
    assign imemAddr  = pc;

    // Only a live outstanding fetch may write; stale or stray words are dropped.
    assign push      = (state_q == WAIT) && imemRespValid && !flush;
    assign instValid = (count_q != '0);
    assign pop       = instValid && instReady && !flush;
    assign inst      = inst_q[rd_ptr_q];
    assign instPc    = pc_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            req_pc_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                inst_q[i] <= '0;
                pc_q[i]   <= DBITS'(START_PC);
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q  <= WAIT;
                        req_pc_q <= pc;
                    end
                end
                WAIT: begin
                    if (imemRespValid) begin
                        state_q <= IDLE;
                    end else if (flush) begin
                        state_q <= DROP;
                    end
                end
                DROP: begin
                    if (imemRespValid) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (flush) begin
                count_q  <= '0;
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
            end else begin
                count_q <= count_d;
                if (push) begin
                    inst_q[wr_ptr_q] <= imemRespData;
                    pc_q[wr_ptr_q]   <= req_pc_q;
                    wr_ptr_q         <= wr_ptr_q + 1'b1;
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: memory model with configurable latency, PC register
// model and a scoreboard of expected {inst, instPc} pairs in delivery order.
module tb_fetch_queue;

    logic        clk;
    logic        reset;
    logic [31:0] pc_r;
    logic        flush;
    logic        pcAdvance;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemReqReady;
    logic        imemRespValid;
    logic [31:0] imemRespData;
    logic        instValid;
    logic [31:0] inst;
    logic [31:0] instPc;
    logic        instReady;

    fetch_queue #(.DBITS(32), .START_PC(64), .DEPTH(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .pc            (pc_r),
        .flush         (flush),
        .pcAdvance     (pcAdvance),
        .imemReq       (imemReq),
        .imemAddr      (imemAddr),
        .imemReqReady  (imemReqReady),
        .imemRespValid (imemRespValid),
        .imemRespData  (imemRespData),
        .instValid     (instValid),
        .inst          (inst),
        .instPc        (instPc),
        .instReady     (instReady)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [63:0] sb [$];

    // memory model state
    logic        busy;
    logic        stale;
    logic [31:0] raddr;
    int          cnt;
    int          lat;
    logic        inj;
    logic        adv_pend;

    // snapshots taken mid-cycle
    logic        s_req, s_adv, s_valid, s_rv;
    logic [31:0] s_inst, s_ipc, s_addr;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return 32'hAAAA0000 + ((a - 32'd60) >> 2);
    endfunction

    task automatic tick();
        logic [63:0] head;
        @(negedge clk);
        s_req   = imemReq;
        s_adv   = pcAdvance;
        s_valid = instValid;
        s_inst  = inst;
        s_ipc   = instPc;
        s_rv    = imemRespValid;
        s_addr  = imemAddr;
        if (!reset) begin
            checks++;
            if (s_valid !== (sb.size() != 0)) begin
                errors++;
                $display("FAIL valid t=%0t got %b exp %b", $time,
                         s_valid, sb.size() != 0);
            end
            if (s_valid === 1'b1 && sb.size() != 0) begin
                head = sb[0];
                checks++;
                if ({s_inst, s_ipc} !== head) begin
                    errors++;
                    $display("FAIL head t=%0t got %h/%h exp %h/%h", $time,
                             s_inst, s_ipc, head[63:32], head[31:0]);
                end
            end
            checks++;
            if (s_adv !== (s_req && imemReqReady)) begin
                errors++;
                $display("FAIL pcAdvance t=%0t got %b exp %b", $time,
                         s_adv, s_req && imemReqReady);
            end
            if (s_req === 1'b1) begin
                checks++;
                if (s_addr !== pc_r) begin
                    errors++;
                    $display("FAIL imemAddr t=%0t got %h exp %h", $time,
                             s_addr, pc_r);
                end
            end
        end
        if (s_valid === 1'b1 && instReady && !flush && !reset
            && sb.size() != 0) begin
            void'(sb.pop_front());
        end
        if (reset || flush) sb.delete();
        if (s_rv) begin
            if (busy && !stale && !flush && !reset)
                sb.push_back({mdata(raddr), raddr});
            busy = 1'b0;
        end
        adv_pend = 1'b0;
        if (reset) begin
            busy = 1'b0;
        end else if (s_adv === 1'b1) begin
            busy     = 1'b1;
            stale    = 1'b0;
            raddr    = s_addr;
            cnt      = lat;
            adv_pend = 1'b1;
        end else if (busy && flush) begin
            stale = 1'b1;
        end
        @(posedge clk);
        #1;
        if (adv_pend) pc_r = pc_r + 32'd4;
        if (busy && cnt > 0) cnt--;
        imemRespValid = (busy && cnt == 0) || inj;
        imemRespData  = inj ? 32'hDEAD0000 : mdata(raddr);
        inj = 1'b0;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        flush        = 1'b0;
        instReady    = 1'b0;
        imemReqReady = 1'b1;
        inj          = 1'b0;
        lat          = 1;
        pc_r         = 32'd64;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        instReady = 1'b1;
        tick();
        checks++;
        if (s_valid !== 1'b0 || s_ipc !== 32'd64 || s_inst !== 32'd0) begin
            errors++;
            $display("FAIL reset_state got v=%b pc=%h i=%h exp 0/40/0",
                     s_valid, s_ipc, s_inst);
        end
        checks++;
        if (s_req !== 1'b1 || s_adv !== 1'b1) begin
            errors++;
            $display("FAIL first_req got req=%b adv=%b exp 1/1", s_req, s_adv);
        end
        tick();
        checks++;
        if (s_rv !== 1'b1 || s_valid !== 1'b0) begin
            errors++;
            $display("FAIL resp_cycle got rv=%b v=%b exp 1/0", s_rv, s_valid);
        end
        tick();
        checks++;
        if (s_valid !== 1'b1 || s_inst !== 32'hAAAA0001 || s_ipc !== 32'd64) begin
            errors++;
            $display("FAIL first_word got v=%b i=%h pc=%h exp 1/aaaa0001/40",
                     s_valid, s_inst, s_ipc);
        end
        repeat (6) tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        repeat (4) tick();
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (s_req !== 1'b0 || s_adv !== 1'b0 || s_valid !== 1'b1) begin
                errors++;
                $display("FAIL full_stall got req=%b adv=%b v=%b exp 0/0/1",
                         s_req, s_adv, s_valid);
            end
        end
        instReady = 1'b1;
        tick();
        checks++;
        if (s_ipc !== 32'd64 || s_req !== 1'b0) begin
            errors++;
            $display("FAIL pop_first got pc=%h req=%b exp 40/0", s_ipc, s_req);
        end
        tick();
        checks++;
        if (s_ipc !== 32'd68 || s_req !== 1'b1) begin
            errors++;
            $display("FAIL pop_second got pc=%h req=%b exp 44/1", s_ipc, s_req);
        end
        repeat (6) tick();
    endtask

    task automatic test_flush_wait();
        bit seen;
        do_reset();
        lat = 3;
        tick();
        flush = 1'b1;
        pc_r  = 32'h200;
        tick();
        flush = 1'b0;
        tick();
        checks++;
        if (s_req !== 1'b0) begin
            errors++;
            $display("FAIL drop_noreq got %b exp 0", s_req);
        end
        tick();
        checks++;
        if (s_rv !== 1'b1 || s_req !== 1'b0) begin
            errors++;
            $display("FAIL drop_resp got rv=%b req=%b exp 1/0", s_rv, s_req);
        end
        lat = 1;
        instReady = 1'b1;
        tick();
        checks++;
        if (s_valid !== 1'b0 || s_req !== 1'b1 || s_addr !== 32'h200) begin
            errors++;
            $display("FAIL after_drop got v=%b req=%b a=%h exp 0/1/200",
                     s_valid, s_req, s_addr);
        end
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (s_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen || s_ipc !== 32'h200) begin
            errors++;
            $display("FAIL redirect_pc got seen=%b pc=%h exp 1/200", seen, s_ipc);
        end
        repeat (4) tick();
    endtask

    task automatic test_flush_resp();
        do_reset();
        repeat (3) tick();
        flush = 1'b1;
        pc_r  = 32'h300;
        tick();
        flush = 1'b0;
        checks++;
        if (s_rv !== 1'b1 || s_valid !== 1'b1) begin
            errors++;
            $display("FAIL flush_setup got rv=%b v=%b exp 1/1", s_rv, s_valid);
        end
        tick();
        checks++;
        if (s_valid !== 1'b0 || s_req !== 1'b1 || s_addr !== 32'h300) begin
            errors++;
            $display("FAIL flush_resp got v=%b req=%b a=%h exp 0/1/300",
                     s_valid, s_req, s_addr);
        end
        repeat (4) tick();
    endtask

    task automatic test_push_pop();
        do_reset();
        repeat (3) tick();
        instReady = 1'b1;
        tick();
        instReady = 1'b0;
        tick();
        checks++;
        if (s_valid !== 1'b1 || s_ipc !== 32'd68 || s_inst !== mdata(32'd68)) begin
            errors++;
            $display("FAIL push_pop got v=%b pc=%h i=%h exp 1/44/%h",
                     s_valid, s_ipc, s_inst, mdata(32'd68));
        end
        tick();
        checks++;
        if (s_ipc !== 32'd68) begin
            errors++;
            $display("FAIL push_pop_hold got pc=%h exp 44", s_ipc);
        end
        instReady = 1'b1;
        repeat (6) tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        repeat (2) tick();
        lat = 4;
        tick();
        reset        = 1'b1;
        pc_r         = 32'd64;
        imemReqReady = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if (s_valid !== 1'b0 || s_ipc !== 32'd64 || s_req !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid got v=%b pc=%h req=%b exp 0/40/1",
                     s_valid, s_ipc, s_req);
        end
        inj = 1'b1;
        tick();
        tick();
        tick();
        checks++;
        if (s_valid !== 1'b0 || s_req !== 1'b1) begin
            errors++;
            $display("FAIL stray_resp got v=%b req=%b exp 0/1", s_valid, s_req);
        end
        lat = 1;
        imemReqReady = 1'b1;
        instReady = 1'b1;
        repeat (6) tick();
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            instReady    = ($urandom_range(0, 3) != 0);
            imemReqReady = ($urandom_range(0, 3) != 0);
            lat          = $urandom_range(1, 3);
            if (!flush && $urandom_range(0, 15) == 0) begin
                flush = 1'b1;
                pc_r  = 32'h1000 + ($urandom_range(0, 63) << 2);
            end else begin
                flush = 1'b0;
            end
            tick();
        end
        flush        = 1'b0;
        instReady    = 1'b1;
        imemReqReady = 1'b0;
        repeat (8) tick();
    endtask

    initial begin
        reset         = 1'b1;
        flush         = 1'b0;
        pc_r          = 32'd64;
        instReady     = 1'b0;
        imemReqReady  = 1'b0;
        imemRespValid = 1'b0;
        imemRespData  = '0;
        busy          = 1'b0;
        stale         = 1'b0;
        raddr         = '0;
        cnt           = 0;
        lat           = 1;
        inj           = 1'b0;
        adv_pend      = 1'b0;
        test_reset();
        test_backpressure();
        test_flush_wait();
        test_flush_resp();
        test_push_pop();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
